clk_div_gen: RTL and testbench

Synthesizable, parametrised clock-enable and divided-clock generator, the successor to our free-running behavioural bench clock. It derives CHANNELS independent divided waveforms from the single system clock, each with a programmable period and high time, plus a one-cycle period-start tick per channel. It sits next to the top-level clock and feeds slow strobes to peripherals and to benches that need realistic, synthesizable timing.

---
 rtl/clk_div_gen.sv | 49 ++++
 tb/tb_clk_div_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: per-channel programmable divided clock and period-start tick generator.
// All channels share en/load so they restart phase-aligned.
module clk_div_gen #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 1,
  parameter int DEF_HIGH = 1
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [CHANNELS*CNT_W-1:0] div_i,
  input  logic [CHANNELS*CNT_W-1:0] high_i,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CNT_W-1:0] div_q, div_d, high_q, high_d, cnt_q, cnt_d;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             run;
    always_comb begin
      run    = en && !load;
      div_d  = load ? div_i[k*CNT_W +: CNT_W] : div_q;
      high_d = load ? high_i[k*CNT_W +: CNT_W] : high_q;
      // Wrap strictly on equality so a full-range divide never rolls over early
      cnt_d  = (!run || cnt_q == div_q) ? '0 : cnt_q + CNT_W'(1);
      clk_d  = run && (cnt_q < high_q);
      tick_d = run && (cnt_q == '0);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        div_q  <= CNT_W'(DEF_DIV);
        high_q <= CNT_W'(DEF_HIGH);
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        high_q <= high_d;
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign clk_out[k] = clk_q;
    assign tick[k]    = tick_q;
  end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: randomized scoreboard bench; the model derives each output from the
// phase (edges since restart modulo period), independent of any counter implementation.
module tb_clk_div_gen;
  localparam int CH = 2;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              rst, en, load;
  logic [CH*W-1:0]   div_i, high_i;
  logic [CH-1:0]     clk_out, tick;

  clk_div_gen #(.CHANNELS(CH), .CNT_W(W), .DEF_DIV(1), .DEF_HIGH(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .div_i(div_i), .high_i(high_i), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  logic [CH-1:0] exp_co_q[$];
  logic [CH-1:0] exp_tk_q[$];
  int tests = 0;
  int fails = 0;

  int div_m[CH];
  int high_m[CH];
  int run_t;

  function automatic logic [CH*W-1:0] pk(input int a0, input int a1);
    logic [W-1:0] b0, b1;
    b0 = W'(a0);
    b1 = W'(a1);
    return {b1, b0};
  endfunction

  // Drive one edge's inputs, predict that edge's outputs, then advance past the edge.
  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic [CH*W-1:0] d, input logic [CH*W-1:0] h);
    logic [CH-1:0] co, tk;
    int ph;
    rst = r; load = l; en = e; div_i = d; high_i = h;
    co = '0; tk = '0;
    if (r) begin
      for (int k = 0; k < CH; k++) begin div_m[k] = 1; high_m[k] = 1; end
      run_t = 0;
    end else if (l) begin
      for (int k = 0; k < CH; k++) begin
        div_m[k]  = int'(d[k*W +: W]);
        high_m[k] = int'(h[k*W +: W]);
      end
      run_t = 0;
    end else if (!e) begin
      run_t = 0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        ph    = run_t % (div_m[k] + 1);
        co[k] = (ph < high_m[k]);
        tk[k] = (ph == 0);
      end
      run_t++;
    end
    exp_co_q.push_back(co);
    exp_tk_q.push_back(tk);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic e, input logic [CH*W-1:0] d, input logic [CH*W-1:0] h);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, e, d, h);
  endtask

  // Monitor: predictions queued before an edge are checked on the following falling edge.
  initial begin
    int n;
    logic [CH-1:0] eco, etk;
    forever begin
      @(posedge clk);
      n = exp_co_q.size();
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        eco = exp_co_q.pop_front();
        etk = exp_tk_q.pop_front();
        tests++;
        if (clk_out !== eco) begin
          fails++;
          $display("FAIL clk_out @%0t: got %b expected %b", $time, clk_out, eco);
        end
        tests++;
        if (tick !== etk) begin
          fails++;
          $display("FAIL tick @%0t: got %b expected %b", $time, tick, etk);
        end
      end
    end
  end

  initial begin
    logic [CH*W-1:0] d, h;
    rst = 1'b1; load = 1'b0; en = 1'b0; div_i = '0; high_i = '0;
    run_t = 0;
    for (int k = 0; k < CH; k++) begin div_m[k] = 1; high_m[k] = 1; end
    // Reset defaults, then period-2 waveform
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    run(20, 1'b1, '0, '0);
    // Main configuration: ch0 div3/high1, ch1 div4/high2
    cyc(1'b0, 1'b1, 1'b1, pk(3, 4), pk(1, 2));
    run(45, 1'b1, '0, '0);
    // Mid-run input change without load must be ignored
    run(10, 1'b1, pk(0, 7), pk(5, 0));
    // high=0 and high>=period
    cyc(1'b0, 1'b1, 1'b1, pk(3, 3), pk(0, 9));
    run(12, 1'b1, '0, '0);
    // div=0: tick every cycle
    cyc(1'b0, 1'b1, 1'b1, pk(0, 0), pk(1, 0));
    run(6, 1'b1, '0, '0);
    // en dropped mid-period then restored
    cyc(1'b0, 1'b1, 1'b1, pk(3, 3), pk(2, 2));
    run(3, 1'b1, '0, '0);
    run(2, 1'b0, '0, '0);
    run(8, 1'b1, '0, '0);
    // rst beats load and en
    cyc(1'b1, 1'b1, 1'b1, pk(5, 6), pk(3, 3));
    run(6, 1'b1, '0, '0);
    // load while stopped
    cyc(1'b0, 1'b1, 1'b0, pk(2, 5), pk(1, 4));
    run(3, 1'b0, '0, '0);
    run(10, 1'b1, '0, '0);
    // Full-range divide, 50% duty
    cyc(1'b0, 1'b1, 1'b1, pk(255, 255), pk(128, 128));
    run(600, 1'b1, '0, '0);
    // Randomized control and configuration
    for (int i = 0; i < 1500; i++) begin
      d = pk(($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7),
             $urandom_range(0, 9));
      h = pk($urandom_range(0, 9), $urandom_range(0, 11));
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 9) != 0), d, h);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_co_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d predictions unchecked, expected 0", exp_co_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
